// File: rtl/raytracing_scheduler_pkg.sv
// rtl/raytracing_scheduler_pkg.sv - shared types for the ray tracing line scheduler
package raytracing_scheduler_pkg;

  localparam int SPHERE_W = 64;
  localparam int COLOR_W  = 12;

  typedef logic [SPHERE_W-1:0] sphere_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } color_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RENDER,
    S_COMMIT
  } sched_state_t;

endpackage

// File: rtl/raytracing_scene_bank.sv
// rtl/raytracing_scene_bank.sv - shadow scene written over SPI, copied to the active scene at frame start
module raytracing_scene_bank
  import raytracing_scheduler_pkg::*;
#(
  parameter int N_SPHERES = 4,
  parameter int IDX_W     = 2
) (
  input  logic                          CLK100MHZ,
  input  logic                          ck_rst_,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  sphere_t                       wr_data,
  input  logic                          commit,
  output logic [N_SPHERES*SPHERE_W-1:0] scene
);

  sphere_t shadow [N_SPHERES];

  // Commit reads the pre-edge shadow, so a write on the same edge lands only in the next frame.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      for (int i = 0; i < N_SPHERES; i++) shadow[i] <= '0;
      scene <= '0;
    end else begin
      if (commit) begin
        for (int i = 0; i < N_SPHERES; i++) scene[i*SPHERE_W +: SPHERE_W] <= shadow[i];
      end
      if (wr_en && (int'(wr_idx) < N_SPHERES)) shadow[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/raytracing_scheduler.sv
// rtl/raytracing_scheduler.sv - launches workers per VGA line request and hands the finished line to VGA
// Optional macro RT_SCHED_OVERRUN_CNT_EN adds a saturating dropped-request counter (overrun_cnt).
module raytracing_scheduler
  import raytracing_scheduler_pkg::*;
#(
  parameter int JOBS      = 640,
  parameter int N_WORKERS = 20,
  parameter int N_SPHERES = 4,
  localparam int IDX_W    = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1
) (
  input  logic                          CLK100MHZ,
  input  logic                          ck_rst_,
  input  logic                          recv_dv,
  input  logic [63:0]                   recv_64bit,
  input  logic [IDX_W-1:0]              recv_idx,
  output logic                          recv_interrupt,
  input  logic                          next_line,
  input  logic signed [11:0]            next_y,
  output logic [N_SPHERES*SPHERE_W-1:0] scene,
  output logic                          worker_activate,
  output logic signed [11:0]            worker_y,
  input  logic [N_WORKERS-1:0]          worker_busy,
  input  logic [JOBS*COLOR_W-1:0]       line_color_in,
  output logic [JOBS*COLOR_W-1:0]       line_color_out,
  output logic                          line_valid
`ifdef RT_SCHED_OVERRUN_CNT_EN
  ,
  output logic [15:0]                   overrun_cnt
`endif
);

  if (JOBS % N_WORKERS != 0) begin : g_bad_cfg
    $error("raytracing_scheduler: JOBS must be divisible by N_WORKERS");
  end

  sched_state_t state;
  logic         next_line_q;
  logic         request;
  logic         commit;

  assign request = next_line & ~next_line_q;
  assign commit  = request && (state == S_IDLE) && (next_y == 12'sd0);

  raytracing_scene_bank #(
    .N_SPHERES(N_SPHERES),
    .IDX_W    (IDX_W)
  ) u_scene_bank (
    .CLK100MHZ(CLK100MHZ),
    .ck_rst_  (ck_rst_),
    .wr_en    (recv_dv),
    .wr_idx   (recv_idx),
    .wr_data  (recv_64bit),
    .commit   (commit),
    .scene    (scene)
  );

  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      state           <= S_IDLE;
      next_line_q     <= 1'b0;
      worker_activate <= 1'b0;
      worker_y        <= '0;
      line_color_out  <= '0;
      line_valid      <= 1'b0;
      recv_interrupt  <= 1'b0;
    end else begin
      next_line_q    <= next_line;
      line_valid     <= 1'b0;
      recv_interrupt <= (state == S_IDLE);
      case (state)
        S_IDLE: begin
          if (request) begin
            worker_y        <= next_y;
            worker_activate <= 1'b1;
            state           <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (&worker_busy) begin
            worker_activate <= 1'b0;
            state           <= S_RENDER;
          end
        end
        S_RENDER: begin
          if (worker_busy == '0) state <= S_COMMIT;
        end
        S_COMMIT: begin
          line_color_out <= line_color_in;
          line_valid     <= 1'b1;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RT_SCHED_OVERRUN_CNT_EN
  // Requests arriving while a line is in flight are dropped and only counted here.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      overrun_cnt <= '0;
    end else if (request && (state != S_IDLE) && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_raytracing_scheduler.sv
// tb/tb_raytracing_scheduler.sv - randomized self-checking bench for raytracing_scheduler
module tb_raytracing_scheduler;

  localparam int JOBS = 8;
  localparam int NW   = 4;
  localparam int NS   = 3;
  localparam int IW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 recv_dv;
  logic [63:0]          recv_64bit;
  logic [IW-1:0]        recv_idx;
  logic                 recv_interrupt;
  logic                 next_line;
  logic signed [11:0]   next_y;
  logic [NS*64-1:0]     scene;
  logic                 worker_activate;
  logic signed [11:0]   worker_y;
  logic [NW-1:0]        worker_busy;
  logic [JOBS*12-1:0]   line_color_in;
  logic [JOBS*12-1:0]   line_color_out;
  logic                 line_valid;
`ifdef RT_SCHED_OVERRUN_CNT_EN
  logic [15:0]          overrun_cnt;
`endif

  raytracing_scheduler #(.JOBS(JOBS), .N_WORKERS(NW), .N_SPHERES(NS)) dut (
    .CLK100MHZ      (clk),
    .ck_rst_        (rst_n),
    .recv_dv        (recv_dv),
    .recv_64bit     (recv_64bit),
    .recv_idx       (recv_idx),
    .recv_interrupt (recv_interrupt),
    .next_line      (next_line),
    .next_y         (next_y),
    .scene          (scene),
    .worker_activate(worker_activate),
    .worker_y       (worker_y),
    .worker_busy    (worker_busy),
    .line_color_in  (line_color_in),
    .line_color_out (line_color_out),
    .line_valid     (line_valid)
`ifdef RT_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_cnt    (overrun_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] m_shadow [NS];
  logic [63:0] m_active [NS];
  int          m_ovr;
  int          lv_cnt = 0;
  logic [JOBS*12-1:0] lv_data;

  always @(negedge clk) begin
    if (line_valid === 1'b1) begin
      lv_cnt++;
      lv_data = line_color_out;
    end
  end

  function automatic logic [NS*64-1:0] model_scene();
    logic [NS*64-1:0] r;
    for (int i = 0; i < NS; i++) r[i*64 +: 64] = m_active[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_ovr = 0;
  endtask

  task automatic write_word(input int idx, input logic [63:0] data);
    recv_dv    = 1'b1;
    recv_idx   = IW'(idx);
    recv_64bit = data;
    @(negedge clk);
    recv_dv = 1'b0;
    if (idx < NS) m_shadow[idx] = data;
  endtask

  task automatic run_line(input logic signed [11:0] y, input bit coinc, input bit ovr,
                          input int dly, input int blen);
    logic [JOBS*12-1:0] pix;
    logic [63:0]        cw;
    int                 ci;
    int                 lv0;
    int                 n;
    for (int i = 0; i < JOBS; i++) pix[i*12 +: 12] = 12'($urandom);
    line_color_in = pix;
    lv0 = lv_cnt;
    ci = $urandom_range(0, NS - 1);
    cw = {$urandom, $urandom};
    next_line = 1'b1;
    next_y    = y;
    if (coinc) begin
      recv_dv    = 1'b1;
      recv_idx   = IW'(ci);
      recv_64bit = cw;
    end
    @(negedge clk);
    recv_dv   = 1'b0;
    next_line = 1'b0;
    if (y == 12'sd0) for (int i = 0; i < NS; i++) m_active[i] = m_shadow[i];
    if (coinc) m_shadow[ci] = cw;

    total++;
    if (scene !== model_scene()) begin
      bad++; $display("FAIL scene_at_request y=%0d got=%h exp=%h", y, scene, model_scene());
    end
    total++;
    if (worker_activate !== 1'b1) begin
      bad++; $display("FAIL activate_after_request got=%b exp=1", worker_activate);
    end
    total++;
    if (worker_y !== y) begin
      bad++; $display("FAIL worker_y got=%0d exp=%0d", worker_y, y);
    end

    repeat (dly) @(negedge clk);
    worker_busy = '1;
    n = 0;
    while (worker_activate !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (worker_activate !== 1'b0) begin
      bad++; $display("FAIL launch_timeout activate=%b exp=0", worker_activate);
    end
    total++;
    if (recv_interrupt !== 1'b0) begin
      bad++; $display("FAIL irq_busy got=%b exp=0", recv_interrupt);
    end

    if (ovr) begin
      next_line = 1'b1;
      next_y    = 12'($urandom);
      @(negedge clk);
      next_line = 1'b0;
      if (m_ovr < 65535) m_ovr++;
    end
    write_word($urandom_range(0, NS - 1), {$urandom, $urandom});
    repeat (blen) @(negedge clk);
    worker_busy = '0;

    n = 0;
    while (lv_cnt == lv0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (lv_cnt - lv0 != 1) begin
      bad++; $display("FAIL line_valid_count got=%0d exp=1", lv_cnt - lv0);
    end
    total++;
    if (lv_data !== pix) begin
      bad++; $display("FAIL line_data got=%h exp=%h", lv_data, pix);
    end
    total++;
    if (scene !== model_scene()) begin
      bad++; $display("FAIL scene_after_line got=%h exp=%h", scene, model_scene());
    end
    total++;
    if (recv_interrupt !== 1'b1) begin
      bad++; $display("FAIL irq_idle got=%b exp=1", recv_interrupt);
    end
`ifdef RT_SCHED_OVERRUN_CNT_EN
    total++;
    if (overrun_cnt !== 16'(m_ovr)) begin
      bad++; $display("FAIL overrun_cnt got=%0d exp=%0d", overrun_cnt, m_ovr);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({worker_activate, worker_y, line_valid, recv_interrupt} !== 15'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b/%0d/%b/%b exp=0", worker_activate, worker_y, line_valid, recv_interrupt);
    end
    total++;
    if (line_color_out !== '0 || scene !== '0) begin
      bad++; $display("FAIL reset_data line=%h scene=%h exp=0", line_color_out, scene);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (recv_interrupt !== 1'b1) begin
      bad++; $display("FAIL irq_after_reset got=%b exp=1", recv_interrupt);
    end
  endtask

  task automatic test_basic_line();
    run_line(12'sd5, 1'b0, 1'b0, 3, 10);
  endtask

  task automatic test_scene_commit();
    logic [63:0] held;
    write_word(1, 64'h000A_000A_0000_0280);
    run_line(12'sd0, 1'b0, 1'b0, 1, 2);
    total++;
    if (scene[64 +: 64] !== 64'h000A_000A_0000_0280) begin
      bad++; $display("FAIL scene_slot1 got=%h exp=000a000a00000280", scene[64 +: 64]);
    end
    held = scene[64 +: 64];
    write_word(1, {$urandom, $urandom});
    run_line(12'sd7, 1'b0, 1'b0, 0, 3);
    total++;
    if (scene[64 +: 64] !== held) begin
      bad++; $display("FAIL scene_hold_nonzero_y got=%h exp=%h", scene[64 +: 64], held);
    end
  endtask

  task automatic test_bad_idx();
    write_word(NS, {$urandom, $urandom});
    run_line(12'sd0, 1'b0, 1'b0, 2, 1);
  endtask

  task automatic test_overrun();
    run_line(12'sd9, 1'b0, 1'b1, 1, 4);
    run_line(-12'sd3, 1'b0, 1'b1, 0, 6);
  endtask

  task automatic test_coincident();
    logic [63:0] a;
    a = {$urandom, $urandom};
    write_word(0, a);
    run_line(12'sd0, 1'b1, 1'b0, 1, 2);
    run_line(12'sd0, 1'b1, 1'b0, 0, 1);
    run_line(12'sd0, 1'b0, 1'b0, 2, 2);
  endtask

  task automatic test_reset_mid();
    int n;
    int lv0;
    write_word(2, {$urandom, $urandom});
    run_line(12'sd0, 1'b0, 1'b0, 0, 1);
    for (int i = 0; i < JOBS; i++) line_color_in[i*12 +: 12] = 12'($urandom);
    next_line = 1'b1;
    next_y    = 12'sd3;
    @(negedge clk);
    next_line   = 1'b0;
    worker_busy = '1;
    n = 0;
    while (worker_activate !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (worker_activate !== 1'b0 || worker_y !== 12'sd0 || line_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_ctrl act=%b y=%0d lv=%b exp=0", worker_activate, worker_y, line_valid);
    end
    total++;
    if (line_color_out !== '0 || scene !== '0) begin
      bad++; $display("FAIL mid_reset_data line=%h scene=%h exp=0", line_color_out, scene);
    end
    model_reset();
    worker_busy = '0;
    @(negedge clk);
    rst_n = 1'b1;
    lv0 = lv_cnt;
    repeat (10) @(negedge clk);
    total++;
    if (lv_cnt != lv0) begin
      bad++; $display("FAIL no_line_after_reset got=%0d exp=0", lv_cnt - lv0);
    end
    run_line(12'sd0, 1'b0, 1'b0, 1, 1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) write_word($urandom_range(0, NS), {$urandom, $urandom});
      run_line(($urandom_range(0, 2) == 0) ? 12'sd0 : 12'($urandom),
               1'($urandom), 1'($urandom), $urandom_range(0, 4), $urandom_range(1, 8));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    recv_dv       = 1'b0;
    recv_64bit    = '0;
    recv_idx      = '0;
    next_line     = 1'b0;
    next_y        = '0;
    worker_busy   = '0;
    line_color_in = '0;
    model_reset();
    test_reset();
    test_basic_line();
    test_scene_commit();
    test_bad_idx();
    test_overrun();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
